keypad_emulator: RTL and testbench

Synthesizable 4-row × 3-column matrix-keypad model: the responder side of the row-scan / column-sense protocol used by the keypad scanner. It takes key-press commands over a valid/ready handshake. For each command it closes one key contact with configurable press bounce, hold time, release bounce and inter-key gap, and drives the active-low column lines in response to the scanner's active-low row drive. It is used in hardware-in-the-loop builds and benches to exercise the scanner without a physical keypad.

---
 rtl/keypad_emulator_pkg.sv | 40 ++++
 rtl/keypad_bounce_gen.sv | 50 +++++
 rtl/keypad_emulator.sv | 147 ++++++++++++++
 tb/tb_keypad_emulator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_emulator_pkg.sv
// keypad_emulator_pkg: definitions shared by the keypad emulator and the keypad
// scanner: matrix geometry, FSM state encoding and key-code to row/col mapping.
// Ports: none (package).
package keypad_emulator_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 3;
  localparam int unsigned MAX_KEY  = 11;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned COL_W    = 2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_BOUNCE_PRESS   = 3'd1,
    S_HOLD           = 3'd2,
    S_BOUNCE_RELEASE = 3'd3,
    S_GAP            = 3'd4
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } key_pos_t;

  // Key index = row*3 + col.
  function automatic key_pos_t key_to_pos(input logic [CODE_W-1:0] code);
    key_pos_t pos;
    pos.row = ROW_W'(code / CODE_W'(NUM_COLS));
    pos.col = COL_W'(code % CODE_W'(NUM_COLS));
    return pos;
  endfunction

  function automatic logic key_legal(input logic [CODE_W-1:0] code);
    return code <= CODE_W'(MAX_KEY);
  endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// keypad_bounce_gen: contact bounce pattern source for the keypad emulator.
// Build option: KEYPAD_EMU_LFSR_BOUNCE_EN selects an 8-bit Fibonacci LFSR
// (taps 8,6,5,4, seed 8'hA5); otherwise a 2-closed/2-open square wave.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start        : next cycle is the first cycle of a bounce window
//   advance      : next cycle is a bounce cycle (pattern steps)
//   bit_c        : contact value for the next bounce cycle (combinational)
module keypad_bounce_gen
  import keypad_emulator_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic advance,
  output logic bit_c
);

`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
  logic [7:0] lfsr;
  logic       unused_start;

  assign unused_start = start;

  // Free-running across windows; only steps while bouncing.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign bit_c = lfsr[0];
`else
  logic [1:0] phase;

  // Phase restarts at each window so every window begins closed.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= 2'd0;
    end else if (advance) begin
      phase <= start ? 2'd1 : phase + 2'd1;
    end
  end

  assign bit_c = start ? 1'b1 : ~phase[1];
`endif

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x3 matrix keypad responder. Accepts key-press commands,
// closes the addressed contact with press bounce, hold, release bounce and an
// inter-key gap, and answers the scanner's active-low row drive on cols.
// Build option: KEYPAD_EMU_LFSR_BOUNCE_EN (see keypad_bounce_gen).
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   key_valid    : command valid
//   key_code     : key index 0..11 (12..15 flagged via err)
//   key_ready    : command can be accepted (IDLE only)
//   rows         : scanner row drive, active-low
//   cols         : column sense, active-low, combinational from rows
//   pressed      : contact closed
//   done         : one-cycle pulse in the last gap cycle
//   err          : one-cycle pulse after an illegal code is accepted
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [CODE_W-1:0] key_code,
  output logic              key_ready,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic              pressed,
  output logic              done,
  output logic              err
);

  localparam int unsigned MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int unsigned CNT_TOP = MAX_ALL - 1;
  localparam int unsigned CNT_W   = (CNT_TOP > 1) ? $clog2(CNT_TOP + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic              pressed_n, done_n, err_n, ready_n;
  logic              bounce_bit, bounce_start, bounce_adv, bounce_n;
  key_pos_t          pos;

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      code_q    <= '0;
      pressed   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      code_q    <= code_n;
      pressed   <= pressed_n;
      done      <= done_n;
      err       <= err_n;
      key_ready <= ready_n;
    end
  end

  // Next state, counter reload on every state entry, command latch.
  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    code_n  = code_q;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (key_valid && key_ready) begin
          if (key_legal(key_code)) begin
            code_n  = key_code;
            state_n = S_BOUNCE_PRESS;
            cnt_n   = BOUNCE_LOAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_BOUNCE_PRESS: if (cnt == '0) begin
        state_n = S_HOLD;
        cnt_n   = HOLD_LOAD;
      end
      S_HOLD: if (cnt == '0) begin
        state_n = S_BOUNCE_RELEASE;
        cnt_n   = BOUNCE_LOAD;
      end
      S_BOUNCE_RELEASE: if (cnt == '0) begin
        state_n = S_GAP;
        cnt_n   = GAP_LOAD;
      end
      S_GAP: if (cnt == '0) begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    done_n  = (state_n == S_GAP) && (cnt_n == '0);
    ready_n = (state_n == S_IDLE);
  end

  // Bounce generator steps for each cycle about to be spent bouncing.
  assign bounce_n     = (state_n == S_BOUNCE_PRESS) || (state_n == S_BOUNCE_RELEASE);
  assign bounce_adv   = bounce_n;
  assign bounce_start = bounce_n && (state_n != state);

  keypad_bounce_gen u_bounce (
    .clock   (clock),
    .reset   (reset),
    .start   (bounce_start),
    .advance (bounce_adv),
    .bit_c   (bounce_bit)
  );

  // Contact value for the state being entered; open in IDLE and GAP.
  always_comb begin
    pressed_n = 1'b0;
    if (state_n == S_HOLD) begin
      pressed_n = 1'b1;
    end else if (bounce_n) begin
      pressed_n = bounce_bit;
    end
  end

  // Zero-latency column answer for the latched key.
  assign pos = key_to_pos(code_q);

  always_comb begin
    cols = '1;
    if (pressed && !rows[pos.row]) begin
      cols[pos.col] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed and randomized checks of keypad_emulator
// against a timeline model (B=4, H=20, G=5). Build option
// KEYPAD_EMU_LFSR_BOUNCE_EN switches the bounce reference to the LFSR.
module tb_keypad_emulator;

  localparam int B = 4;
  localparam int H = 20;
  localparam int G = 5;
  localparam int T = 2 * B + H + G;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] rows;
  logic [2:0] cols;
  logic       pressed;
  logic       done;
  logic       err;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] lfsr_m = 8'hA5;

  always #5 clock = ~clock;

  keypad_emulator #(
    .HOLD_CYCLES   (H),
    .BOUNCE_CYCLES (B),
    .GAP_CYCLES    (G)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .rows      (rows),
    .cols      (cols),
    .pressed   (pressed),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fibonacci LFSR step from its tap list (taps counted from 1).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    int   taps [4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i] - 1];
    return {s[6:0], fb};
  endfunction

  // Contact value for bounce cycle i of a window (i counts from 0).
`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
  task automatic bounce_exp(input int i, output logic b);
    b = lfsr_m[0];
    lfsr_m = lfsr_step(lfsr_m);
    if (i < 0) b = 1'bx;
  endtask
`else
  task automatic bounce_exp(input int i, output logic b);
    b = ((i / 2) % 2) == 0;
  endtask
`endif

  function automatic logic [2:0] exp_cols(input int code, input logic p, input logic [3:0] r);
    logic [2:0] c = 3'b111;
    if (p && r[code / 3] == 1'b0) c[code % 3] = 1'b0;
    return c;
  endfunction

  task automatic check_idle_outputs(input string tag, input logic exp_err);
    chk({tag, " pressed"}, 8'(pressed), 8'd0);
    chk({tag, " cols"}, 8'(cols), 8'h7);
    chk({tag, " ready"}, 8'(key_ready), 8'd1);
    chk({tag, " done"}, 8'(done), 8'd0);
    chk({tag, " err"}, 8'(err), 8'(exp_err));
  endtask

  // One command from accept edge n through cycle n+T+1; every cycle checked.
  task automatic run_cmd(input int code, input logic rnd_rows, input logic [3:0] rows_a,
                         input logic [3:0] rows_b, input logic hold, input logic [3:0] next_code,
                         input string tag);
    logic       p_exp;
    logic [3:0] r;
    key_valid = 1'b1;
    key_code  = 4'(code);
    rows      = rows_a;
    @(posedge clock); #1;
    for (int k = 1; k <= T + 1; k++) begin
      if (rnd_rows) r = 4'($urandom);
      else r = (k % 5 == 0) ? rows_b : rows_a;
      rows = r;
      if (hold) begin
        key_valid = 1'b1;
        key_code  = next_code;
      end else if (k <= T) begin
        key_valid = 1'($urandom);
        key_code  = 4'($urandom);
      end else begin
        key_valid = 1'b0;
      end
      if (k <= B) bounce_exp(k - 1, p_exp);
      else if (k <= B + H) p_exp = 1'b1;
      else if (k <= 2 * B + H) bounce_exp(k - B - H - 1, p_exp);
      else p_exp = 1'b0;
      #1;
      chk($sformatf("%s k=%0d pressed", tag, k), 8'(pressed), 8'(p_exp));
      chk($sformatf("%s k=%0d cols", tag, k), 8'(cols), 8'(exp_cols(code, p_exp, r)));
      chk($sformatf("%s k=%0d done", tag, k), 8'(done), 8'(k == T));
      chk($sformatf("%s k=%0d ready", tag, k), 8'(key_ready), 8'(k == T + 1));
      chk($sformatf("%s k=%0d err", tag, k), 8'(err), 8'd0);
      if (k <= T) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic run_illegal(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    rows      = 4'($urandom);
    @(posedge clock); #1;
    key_valid = 1'b0;
    check_idle_outputs($sformatf("illegal%0d n+1", code), 1'b1);
    for (int j = 2; j <= T + 2; j++) begin
      rows = 4'($urandom);
      @(posedge clock); #1;
      check_idle_outputs($sformatf("illegal%0d n+%0d", code, j), 1'b0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    rows      = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("reset", 1'b0);
    reset  = 1'b0;
    lfsr_m = 8'hA5;
    @(posedge clock); #1;
    check_idle_outputs("post_reset", 1'b0);

    // Legal key 4 on row 1, with row 0 only every 5th cycle (isolation).
    run_cmd(4, 1'b0, 4'b1101, 4'b1110, 1'b0, 4'd0, "key4");
    // Bounce pattern on key 11 (row 3, col 2).
    run_cmd(11, 1'b0, 4'b0111, 4'b0111, 1'b0, 4'd0, "key11");

    run_illegal(4'd13);
    run_illegal(4'd12);
    run_illegal(4'd15);

    // Reset while in HOLD (key 5: row 1, col 2).
    key_valid = 1'b1;
    key_code  = 4'd5;
    rows      = 4'b1101;
    @(posedge clock); #1;
    key_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("midreset hold pressed", 8'(pressed), 8'd1);
    chk("midreset hold cols", 8'(cols), 8'h3);
    reset = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("midreset", 1'b0);
    reset  = 1'b0;
    lfsr_m = 8'hA5;
    @(posedge clock); #1;
    check_idle_outputs("midreset_release", 1'b0);

    // Back-to-back: valid held high, code 0 then 2.
    run_cmd(0, 1'b0, 4'b1110, 4'b1110, 1'b1, 4'd2, "b2b0");
    run_cmd(2, 1'b0, 4'b1110, 4'b1110, 1'b0, 4'd0, "b2b2");

    // All rows low: only the latched row counts.
    run_cmd(7, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, "multirow7");

    for (int i = 0; i < 8; i++) begin
      run_cmd(int'($urandom_range(0, 11)), 1'b1, 4'hF, 4'hF, 1'b0, 4'd0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
